dtc_stub_router: RTL and testbench
==================================

# dtc_stub_router

Downstream of the DTC serial-capture stage. It takes each reassembled 256-bit CIC packet, walks its stub slots one per clock, and routes every valid 21-bit stub to the write port of the per-MPA stub BRAM selected by the stub's 3-bit chip ID. It keeps one write pointer and overflow flag per chip, cleared at frame boundaries.

## Interface
Parameters:
- PKT_W, 256, packet width
- STUB_W, 21, stub payload width
- N_SLOTS, 10, stub slots per packet
- N_CHIPS, 8, MPA BRAMs (chip ID width = 3)
- ADDR_W, 7, BRAM address width (128 entries)

Ports:
- clk  in  1  single design clock
- rst  in  1  synchronous, active-low reset
- pkt_valid  in  1  one-cycle strobe: pkt_data holds a complete packet
- pkt_data  in  PKT_W  packet, MSB = first received bit
- frame_clr  in  1  one-cycle strobe: zero all pointers and overflow flags
- busy  out  1  high while a packet is being walked
- pkt_drop  out  1  one-cycle pulse when a packet is refused
- hdr_err  out  1  one-cycle pulse on header mismatch (see Configuration)
- wr_en  out  N_CHIPS  one-hot BRAM write enable
- wr_addr  out  N_CHIPS*ADDR_W  per-chip write address; chip c uses [c*ADDR_W +: ADDR_W]
- wr_data  out  STUB_W  stub payload, shared by all chips
- ovf  out  N_CHIPS  sticky per-chip overflow

## Operation
- Packet layout: [255:248] sync byte; [233:230] stub count n; slot k (k = 0..9) = [229-21k : 209-21k]; chip ID = slot bits [17:15]; [19:0] ignored.
- Effective count is min(n,10). Counts 11–15 are clamped to 10 and are not an error.
- FSM IDLE:
  - pkt_valid with busy low: latch the packet and count, then go to WALK.
  - Effective count 0: stay in IDLE with no writes.
- FSM WALK: slot index i starts at 0. Each cycle, route slot i to its chip and increment i. When i reaches count-1, return to IDLE.
- pkt_valid while busy: the packet is discarded and pkt_drop pulses. The in-flight packet is unaffected.
- Per chip, with 8-bit fill count f (0..128):
  - Write when f < 128: assert wr_en[c], drive wr_addr for chip c with f[6:0], then f <= f+1.
  - When f = 128: no write, ovf[c] <= 1, and the stub is lost.
- frame_clr:
  - All f <= 0 and all ovf <= 0.
  - If a stub is routed in the same cycle, the clear applies first. The stub is written at address 0 and that chip's f becomes 1.
- Reset (rst = 0), any cycle including mid-walk:
  - FSM goes to IDLE and the latched packet is discarded.
  - All fill counts are 0.
  - All outputs are 0.

## Timing
- pkt_valid accepted in cycle T, count n: WALK occupies T+1..T+n.
- Registered outputs:
  - wr_en, wr_addr and wr_data for slot i appear in cycle T+2+i.
  - Latency from pkt_valid to the first write is 2 cycles.
- busy equals (state == WALK): high T+1..T+n, low at T+n+1. The next pkt_valid can be accepted at T+n+1.
- pkt_drop and hdr_err are asserted in cycle T+1, one cycle wide.
- wr_addr for chips not written holds that chip's current f[6:0].

## Configuration
- DTC_ROUTER_HDR_CHECK_EN:
  - Defined: an accepted packet whose [255:248] != 8'hA5 is not walked, hdr_err pulses, and busy stays low.
  - Undefined: no header check and hdr_err is tied to 0.

## Structure
- Package dtc_pkg holds:
  - Width constants: PKT_W, STUB_W, ADDR_W, N_SLOTS, N_CHIPS, SYNC_BYTE = 8'hA5.
  - Slot-offset function slot_lsb(k) = 209-21k.
  - Chip-ID field position [17:15].
  - FSM enum {IDLE, WALK}.
- Sub-module dtc_chip_ptr holds one chip's fill counter, overflow flag and address output. It has a write-request input and frame_clr, and is instantiated N_CHIPS times. The top level holds the FSM, packet latch and output registers.

## Test plan
- Packet with n = 3, chip IDs {2,5,2}, payloads 21'h1A0001/21'h1A0002/21'h1A0003 → expected writes:
  - T+2: wr_en = 8'h04, addr 0, data 21'h1A0001.
  - T+3: wr_en = 8'h20, addr 0.
  - T+4: wr_en = 8'h04, addr 1.
  - busy low at T+4.
- n = 15, all slots chip 0 → 10 writes to chip 0 at addresses 0..9, with no error.
- 130 stubs to chip 7 across 13 packets → addresses 0..127 are written, the last 2 are dropped, ovf = 8'h80, then frame_clr → ovf = 0 and the next write goes to addr 0.
- pkt_valid at T+2 during a 10-stub walk → pkt_drop pulses at T+3; the original 10 writes are unchanged.
- frame_clr coincident with a chip 3 write while f3 = 40 → write at addr 0, f3 = 1; rst low at T+3 of a walk → no further wr_en, busy = 0, all pointers 0.
- With DTC_ROUTER_HDR_CHECK_EN, sync byte 8'h5A → hdr_err pulses at T+1, no writes; without the macro, the same packet is routed normally.

Source files
------------

// File: rtl/dtc_stub_router_pkg.sv
// Shared widths, packet field positions and FSM type for the DTC stub router.
// Packet layout: sync byte at the top, 4-bit stub count, then ten 21-bit stub slots.
package dtc_pkg;

    localparam int PKT_W   = 256;
    localparam int STUB_W  = 21;
    localparam int ADDR_W  = 7;
    localparam int N_SLOTS = 10;
    localparam int N_CHIPS = 8;
    localparam int CHIP_W  = 3;
    localparam int CNT_W   = 4;
    localparam int FILL_W  = ADDR_W + 1;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int SYNC_MSB  = 255;
    localparam int SYNC_LSB  = 248;
    localparam int CNT_MSB   = 233;
    localparam int CNT_LSB   = 230;
    localparam int SLOTS_MSB = 229;
    localparam int SLOTS_LSB = 20;
    localparam int SLOTS_W   = N_SLOTS * STUB_W;

    localparam int CHIP_MSB = 17;
    localparam int CHIP_LSB = 15;

    // Fill count at which a chip's BRAM is full.
    localparam logic [FILL_W-1:0] DEPTH = FILL_W'(1 << ADDR_W);

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    function automatic int slot_lsb(input int k);
        return 209 - 21 * k;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
        return (n > CNT_W'(N_SLOTS)) ? CNT_W'(N_SLOTS) : n;
    endfunction

endpackage

// File: rtl/dtc_stub_router_if.sv
// Packet-in / BRAM-write-out bundle of the DTC stub router.
// master = packet source and BRAM side, slave = the router itself.
interface dtc_stub_router_if;
    import dtc_pkg::*;

    logic                      pkt_valid;
    logic [PKT_W-1:0]          pkt_data;
    logic                      frame_clr;
    logic                      busy;
    logic                      pkt_drop;
    logic                      hdr_err;
    logic [N_CHIPS-1:0]        wr_en;
    logic [N_CHIPS*ADDR_W-1:0] wr_addr;
    logic [STUB_W-1:0]         wr_data;
    logic [N_CHIPS-1:0]        ovf;

    modport master (
        output pkt_valid, pkt_data, frame_clr,
        input  busy, pkt_drop, hdr_err, wr_en, wr_addr, wr_data, ovf
    );

    modport slave (
        input  pkt_valid, pkt_data, frame_clr,
        output busy, pkt_drop, hdr_err, wr_en, wr_addr, wr_data, ovf
    );

endinterface

// File: rtl/dtc_stub_router_chip_ptr.sv
// dtc_chip_ptr: one MPA chip's BRAM fill counter, sticky overflow flag and registered
// write enable / address. A frame clear takes effect before a same-cycle write.
import dtc_pkg::*;

module dtc_chip_ptr (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              frame_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addr,
    output logic              ovf
);

    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] base;
    logic [FILL_W-1:0] fill_d;
    logic              room;
    logic              do_wr;
    logic              ovf_d;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        base   = frame_clr ? '0 : fill_q;
        room   = (base < DEPTH);
        do_wr  = wr_req && room;
        fill_d = do_wr ? (base + FILL_W'(1)) : base;
        ovf_d  = frame_clr ? 1'b0 : (ovf | (wr_req & ~room));
        // A written chip shows the address it wrote; idle chips show their fill level.
        addr_d = do_wr ? base[ADDR_W-1:0] : fill_d[ADDR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_q <= '0;
            wr_en  <= 1'b0;
            addr   <= '0;
            ovf    <= 1'b0;
        end else begin
            fill_q <= fill_d;
            wr_en  <= do_wr;
            addr   <= addr_d;
            ovf    <= ovf_d;
        end
    end

endmodule

// File: rtl/dtc_stub_router.sv
// dtc_stub_router: latches an accepted CIC packet and routes one stub slot per clock
// to the BRAM of its chip. Build macro DTC_ROUTER_HDR_CHECK_EN enables the sync-byte check.
import dtc_pkg::*;

module dtc_stub_router (
    input logic              clk,
    input logic              rst,
    dtc_stub_router_if.slave bus
);

    state_t                    state_q;
    state_t                    state_d;
    logic [CNT_W-1:0]          eff_cnt;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          idx_q;
    logic [SLOTS_W-1:0]        slots_q;
    logic [STUB_W-1:0]         slot_arr [N_SLOTS];
    logic [STUB_W-1:0]         cur_stub;
    logic [STUB_W-1:0]         wr_data_q;
    logic [CHIP_W-1:0]         chip_sel;
    logic                      hdr_ok;
    logic                      accept;
    logic                      start;
    logic                      last_slot;
    logic                      busy_c;
    logic                      route_c;
    logic                      drop_c;
    logic                      herr_c;
    logic                      pkt_drop_q;
    logic                      hdr_err_q;
    logic [N_CHIPS-1:0]        req;
    logic [N_CHIPS-1:0]        wr_en_w;
    logic [N_CHIPS-1:0]        ovf_w;
    logic [N_CHIPS*ADDR_W-1:0] wr_addr_w;
    logic                      unused_bits;

    assign eff_cnt = clamp_count(bus.pkt_data[CNT_MSB:CNT_LSB]);

`ifdef DTC_ROUTER_HDR_CHECK_EN
    assign hdr_ok      = (bus.pkt_data[SYNC_MSB:SYNC_LSB] == SYNC_BYTE);
    assign unused_bits = ^{bus.pkt_data[SYNC_LSB-1:CNT_MSB+1], bus.pkt_data[SLOTS_LSB-1:0]};
`else
    assign hdr_ok      = 1'b1;
    assign unused_bits = ^{bus.pkt_data[SYNC_MSB:CNT_MSB+1], bus.pkt_data[SLOTS_LSB-1:0]};
`endif

    assign accept    = (state_q == IDLE) && bus.pkt_valid;
    assign start     = accept && hdr_ok && (eff_cnt != '0);
    assign last_slot = (idx_q == (cnt_q - CNT_W'(1)));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WALK;
            WALK:    if (last_slot) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_c  = 1'b0;
        route_c = 1'b0;
        drop_c  = 1'b0;
        herr_c  = 1'b0;
        case (state_q)
            IDLE: herr_c = accept && !hdr_ok;
            WALK: begin
                busy_c  = 1'b1;
                route_c = 1'b1;
                drop_c  = bus.pkt_valid;
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        assign slot_arr[k] = slots_q[slot_lsb(k) - SLOTS_LSB +: STUB_W];
    end

    assign cur_stub = slot_arr[idx_q];
    assign chip_sel = cur_stub[CHIP_MSB:CHIP_LSB];

    // Packet latch: only the slot region is kept, the walk reads it one slot per cycle.
    always_ff @(posedge clk) begin
        if (start) begin
            slots_q <= bus.pkt_data[SLOTS_MSB:SLOTS_LSB];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pkt_drop_q <= 1'b0;
            hdr_err_q  <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            if (start) begin
                cnt_q <= eff_cnt;
                idx_q <= '0;
            end else if (busy_c) begin
                idx_q <= idx_q + CNT_W'(1);
            end
            pkt_drop_q <= drop_c;
            hdr_err_q  <= herr_c;
            if (route_c) begin
                wr_data_q <= cur_stub;
            end
        end
    end

    for (genvar c = 0; c < N_CHIPS; c++) begin : g_chip
        assign req[c] = route_c && (chip_sel == CHIP_W'(c));

        dtc_chip_ptr u_ptr (
            .clk       (clk),
            .rst       (rst),
            .wr_req    (req[c]),
            .frame_clr (bus.frame_clr),
            .wr_en     (wr_en_w[c]),
            .addr      (wr_addr_w[c*ADDR_W +: ADDR_W]),
            .ovf       (ovf_w[c])
        );
    end

    assign bus.busy     = busy_c;
    assign bus.pkt_drop = pkt_drop_q;
    assign bus.hdr_err  = hdr_err_q;
    assign bus.wr_en    = wr_en_w;
    assign bus.wr_addr  = wr_addr_w;
    assign bus.wr_data  = wr_data_q;
    assign bus.ovf      = ovf_w;

endmodule

// File: tb/tb_dtc_stub_router.sv
// Bench for dtc_stub_router: a transaction-level model checks every output each cycle,
// and directed packets with hand-computed expectations pin the model's results.
module tb_dtc_stub_router;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    dtc_stub_router_if bus ();

    dtc_stub_router dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        logic [20:0] data;
    } wr_t;

    // Model state: expected outputs for the current cycle.
    wr_t         sched[$];
    logic [7:0]  fill [8];
    logic [7:0]  ovf_m = '0;
    logic [7:0]  exp_en = '0;
    logic [6:0]  exp_addr [8];
    logic [20:0] exp_data = '0;
    logic        exp_busy = 1'b0;
    logic        exp_drop = 1'b0;
    logic        exp_herr = 1'b0;
    int          walk_lo = 1;
    int          walk_hi = 0;

    logic [20:0] st [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [20:0] mk_stub(input int chip, input logic [20:0] payload);
        logic [20:0] s;
        s        = payload;
        s[17:15] = chip[2:0];
        return s;
    endfunction

    function automatic logic [255:0] mk_pkt(input logic [7:0] sync, input logic [3:0] n);
        logic [255:0] p;
        p            = '0;
        p[255:248]   = sync;
        p[233:230]   = n;
        for (int k = 0; k < 10; k++) p[(209 - 21*k) +: 21] = st[k];
        return p;
    endfunction

    function automatic logic [6:0] addr_of(input int c);
        logic [55:0] a;
        a = bus.wr_addr;
        return a[c*7 +: 7];
    endfunction

    // Behavioural model: consumes the inputs of cycle t at the edge, predicts cycle t+1.
    initial begin
        for (int c = 0; c < 8; c++) begin
            fill[c]     = '0;
            exp_addr[c] = '0;
        end
        forever begin
            @(posedge clk);
            begin
                int          t;
                int          eff;
                int          c;
                logic        busy_now;
                logic        hdr_ok;
                logic [255:0] pd;
                wr_t         w;
                t = cyc;
                if (!rst) begin
                    sched.delete();
                    for (int k = 0; k < 8; k++) begin
                        fill[k]     = '0;
                        exp_addr[k] = '0;
                    end
                    ovf_m = '0; exp_en = '0; exp_data = '0;
                    exp_busy = 0; exp_drop = 0; exp_herr = 0;
                    walk_lo = 1; walk_hi = 0;
                end else begin
                    busy_now = (t >= walk_lo) && (t <= walk_hi);
                    if (bus.frame_clr) begin
                        for (int k = 0; k < 8; k++) fill[k] = '0;
                        ovf_m = '0;
                    end
                    exp_en = '0;
                    if (sched.size() > 0 && sched[0].at == t + 1) begin
                        w = sched.pop_front();
                        c = int'(w.data[17:15]);
                        exp_data = w.data;
                        if (fill[c] < 8'd128) begin
                            exp_en[c]   = 1'b1;
                            exp_addr[c] = fill[c][6:0];
                            fill[c]     = fill[c] + 8'd1;
                        end else begin
                            ovf_m[c] = 1'b1;
                        end
                    end
                    for (int k = 0; k < 8; k++) if (!exp_en[k]) exp_addr[k] = fill[k][6:0];
                    exp_drop = bus.pkt_valid && busy_now;
                    exp_herr = 1'b0;
                    if (bus.pkt_valid && !busy_now) begin
                        pd  = bus.pkt_data;
                        eff = int'(pd[233:230]);
                        if (eff > 10) eff = 10;
`ifdef DTC_ROUTER_HDR_CHECK_EN
                        hdr_ok = (pd[255:248] == 8'hA5);
`else
                        hdr_ok = 1'b1;
`endif
                        if (!hdr_ok) begin
                            exp_herr = 1'b1;
                        end else if (eff > 0) begin
                            walk_lo = t + 1;
                            walk_hi = t + eff;
                            for (int i = 0; i < eff; i++) begin
                                w.at   = t + 2 + i;
                                w.data = pd[(209 - 21*i) +: 21];
                                sched.push_back(w);
                            end
                        end
                    end
                    exp_busy = (t + 1 >= walk_lo) && (t + 1 <= walk_hi);
                end
                cyc = t + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("wr_en", 64'(bus.wr_en), 64'(exp_en));
                for (int c = 0; c < 8; c++) chk($sformatf("wr_addr[%0d]", c), 64'(addr_of(c)), 64'(exp_addr[c]));
                if (exp_en != '0) chk("wr_data", 64'(bus.wr_data), 64'(exp_data));
                chk("busy", 64'(bus.busy), 64'(exp_busy));
                chk("pkt_drop", 64'(bus.pkt_drop), 64'(exp_drop));
                chk("hdr_err", 64'(bus.hdr_err), 64'(exp_herr));
                chk("ovf", 64'(bus.ovf), 64'(ovf_m));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic goto(input int n);
        for (int g = 0; g < 2000 && cyc < n; g++) tick();
    endtask

    task automatic send(input logic [255:0] p, output int t);
        bus.pkt_data  = p;
        bus.pkt_valid = 1'b1;
        t             = cyc;
        tick();
        bus.pkt_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        bus.frame_clr = 1'b1;
        tick();
        bus.frame_clr = 1'b0;
    endtask

    task automatic all_chip(input int chip, input logic [20:0] base);
        for (int k = 0; k < 10; k++) st[k] = mk_stub(chip, base + 21'(k));
    endtask

    initial begin
        int t;
        bus.pkt_valid = 1'b0;
        bus.pkt_data  = '0;
        bus.frame_clr = 1'b0;
        for (int k = 0; k < 10; k++) st[k] = '0;
        run(3);
        chk("reset wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        rst = 1'b1;
        run(2);

        // Three stubs to chips 2, 5, 2.
        st[0] = mk_stub(2, 21'h1A0001);
        st[1] = mk_stub(5, 21'h1A0002);
        st[2] = mk_stub(2, 21'h1A0003);
        send(mk_pkt(8'hA5, 4'd3), t);
        goto(t + 2);
        chk("t1 en0", 64'(bus.wr_en), 64'h04);
        chk("t1 addr0", 64'(addr_of(2)), 64'd0);
        chk("t1 data0", 64'(bus.wr_data), 64'h190001);
        goto(t + 3);
        chk("t1 en1", 64'(bus.wr_en), 64'h20);
        chk("t1 addr1", 64'(addr_of(5)), 64'd0);
        goto(t + 4);
        chk("t1 en2", 64'(bus.wr_en), 64'h04);
        chk("t1 addr2", 64'(addr_of(2)), 64'd1);
        chk("t1 data2", 64'(bus.wr_data), 64'h190003);
        chk("t1 busy", 64'(bus.busy), 64'd0);
        run(2);
        clr_pulse();

        // Count 15 clamps to 10, all to chip 0.
        all_chip(0, 21'h100000);
        send(mk_pkt(8'hA5, 4'd15), t);
        goto(t + 11);
        chk("t2 en9", 64'(bus.wr_en), 64'h01);
        chk("t2 addr9", 64'(addr_of(0)), 64'd9);
        chk("t2 data9", 64'(bus.wr_data), 64'h100009);
        goto(t + 12);
        chk("t2 done", 64'(bus.wr_en), 64'h00);
        run(2);
        clr_pulse();

        // 130 stubs to chip 7: last two overflow.
        for (int p = 0; p < 13; p++) begin
            all_chip(7, 21'(p * 16));
            send(mk_pkt(8'hA5, 4'd10), t);
            run(10);
        end
        chk("t3 ovf", 64'(bus.ovf), 64'h80);
        clr_pulse();
        chk("t3 ovf clr", 64'(bus.ovf), 64'h00);
        st[0] = mk_stub(7, 21'h000777);
        send(mk_pkt(8'hA5, 4'd1), t);
        goto(t + 2);
        chk("t3 en", 64'(bus.wr_en), 64'h80);
        chk("t3 addr", 64'(addr_of(7)), 64'd0);
        run(2);

        // Packet offered mid-walk is dropped.
        for (int k = 0; k < 10; k++) st[k] = mk_stub(k % 8, 21'h0F000 + 21'(k));
        send(mk_pkt(8'hA5, 4'd10), t);
        goto(t + 2);
        all_chip(6, 21'h000600);
        send(mk_pkt(8'hA5, 4'd10), t);
        chk("t4 drop", 64'(bus.pkt_drop), 64'd1);
        run(12);
        clr_pulse();

        // Frame clear on a chip 3 write at fill 40, then reset mid-walk.
        for (int p = 0; p < 4; p++) begin
            all_chip(3, 21'(p * 32));
            send(mk_pkt(8'hA5, 4'd10), t);
            run(10);
        end
        for (int k = 0; k < 10; k++) st[k] = mk_stub(1, 21'h000100 + 21'(k));
        st[0] = mk_stub(3, 21'h000333);
        send(mk_pkt(8'hA5, 4'd10), t);
        bus.frame_clr = 1'b1;
        tick();
        bus.frame_clr = 1'b0;
        chk("t5 en", 64'(bus.wr_en), 64'h08);
        chk("t5 addr", 64'(addr_of(3)), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t5 rst en", 64'(bus.wr_en), 64'h00);
        chk("t5 rst busy", 64'(bus.busy), 64'd0);
        chk("t5 rst addr", 64'(bus.wr_addr), 64'd0);
        chk("t5 rst ovf", 64'(bus.ovf), 64'd0);
        run(12);

        // Bad sync byte.
        st[0] = mk_stub(4, 21'h000444);
        st[1] = mk_stub(6, 21'h000666);
        send(mk_pkt(8'h5A, 4'd2), t);
`ifdef DTC_ROUTER_HDR_CHECK_EN
        chk("t6 hdr_err", 64'(bus.hdr_err), 64'd1);
        chk("t6 busy", 64'(bus.busy), 64'd0);
`else
        chk("t6 hdr_err", 64'(bus.hdr_err), 64'd0);
        chk("t6 busy", 64'(bus.busy), 64'd1);
`endif
        run(4);

        // Zero count stays idle.
        send(mk_pkt(8'hA5, 4'd0), t);
        chk("t7 busy", 64'(bus.busy), 64'd0);
        run(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
